// File: rtl/spart_core.sv
// spart_core: bus-mapped SPART with a programmable baud divisor and independent TX/RX engines.
// Define SPART_FRAMING_ERR_EN to check the RX stop bit and report framing errors in status bit 3.
module spart_core #(
    parameter logic [15:0] DIV_RESET = 16'd5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_LOAD  = 3'd1,
        TX_START = 3'd2,
        TX_DATA  = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START_CHK = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    logic [15:0] divisor;
    logic [15:0] eff_div;
    logic [15:0] half_div;
    logic        wr_en;
    logic        rd_en;
    logic        wr_tx;
    logic        rd_buf;
    logic        rd_stat;
    logic [7:0]  rd_data;

    tx_state_t   tx_state;
    logic [15:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic [9:0]  tx_shift;

    rx_state_t   rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_buf;
    logic        rx_s1;
    logic        rx_s2;
    logic        ovr;
    logic        ferr;
    logic        stop_ok;

`ifdef SPART_FRAMING_ERR_EN
    assign stop_ok = rx_s2;
`else
    assign ferr    = 1'b0;
    assign stop_ok = 1'b1;
`endif

    // Bus access decode.
    always_comb begin
        wr_en   = iocs & ~iorw;
        rd_en   = iocs & iorw;
        wr_tx   = wr_en & (ioaddr == 2'b00) & tbr;
        rd_buf  = rd_en & (ioaddr == 2'b00);
        rd_stat = rd_en & (ioaddr == 2'b01);
    end

    // Effective bit period, clamped to a minimum of two cycles.
    always_comb begin
        if (divisor < 16'd2) begin
            eff_div = 16'd2;
        end else begin
            eff_div = divisor;
        end
        half_div = {1'b0, eff_div[15:1]};
    end

    // Register read mux.
    always_comb begin
        case (ioaddr)
            2'b00:   rd_data = rx_buf;
            2'b01:   rd_data = {4'b0000, ferr, ovr, tbr, rda};
            2'b10:   rd_data = divisor[7:0];
            2'b11:   rd_data = divisor[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    assign databus = rd_en ? rd_data : 8'hzz;

    // Divisor register; each engine picks up a new value at its next bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor <= DIV_RESET;
        end else if (wr_en && (ioaddr == 2'b10)) begin
            divisor[7:0] <= databus;
        end else if (wr_en && (ioaddr == 2'b11)) begin
            divisor[15:8] <= databus;
        end
    end

    // Two-flop synchronizer for rxd, reset to the idle (mark) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
        end
    end

    // Transmit engine: the shift register holds {stop, data, start} and drains LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 4'd0;
            tx_shift <= 10'h3FF;
            txd      <= 1'b1;
            tbr      <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (wr_tx) begin
                        tx_shift <= {1'b1, databus, 1'b0};
                        tbr      <= 1'b0;
                        tx_state <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    txd      <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[9:1]};
                    tx_bit   <= 4'd0;
                    tx_cnt   <= eff_div - 16'd1;
                    tx_state <= TX_START;
                end
                TX_START, TX_DATA, TX_STOP: begin
                    if (tx_cnt != 16'd0) begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end else if (tx_state == TX_STOP) begin
                        txd      <= 1'b1;
                        tbr      <= 1'b1;
                        tx_state <= TX_IDLE;
                    end else begin
                        txd      <= tx_shift[0];
                        tx_shift <= {1'b1, tx_shift[9:1]};
                        tx_bit   <= tx_bit + 4'd1;
                        tx_cnt   <= eff_div - 16'd1;
                        if (tx_bit == 4'd8) begin
                            tx_state <= TX_STOP;
                        end else begin
                            tx_state <= TX_DATA;
                        end
                    end
                end
                default: begin
                    txd      <= 1'b1;
                    tbr      <= 1'b1;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // Receive engine and status flags; a buffer load overrides a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_buf   <= 8'h00;
            rda      <= 1'b0;
            ovr      <= 1'b0;
`ifdef SPART_FRAMING_ERR_EN
            ferr     <= 1'b0;
`endif
        end else begin
            if (rd_buf) begin
                rda <= 1'b0;
            end
            if (rd_stat) begin
                ovr  <= 1'b0;
`ifdef SPART_FRAMING_ERR_EN
                ferr <= 1'b0;
`endif
            end
            case (rx_state)
                RX_IDLE: begin
                    // Early edge detect on the first stage; START_CHK re-qualifies it on rx_s2.
                    if (rx_s2 && !rx_s1) begin
                        rx_cnt   <= half_div - 16'd1;
                        rx_state <= RX_START_CHK;
                    end
                end
                RX_START_CHK: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else if (!rx_s2) begin
                        rx_cnt   <= eff_div - 16'd1;
                        rx_bit   <= 3'd0;
                        rx_state <= RX_DATA;
                    end else begin
                        rx_state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= eff_div - 16'd1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else if (stop_ok) begin
                        rx_buf   <= rx_shift;
                        rda      <= 1'b1;
                        rx_state <= RX_IDLE;
                        if (rda && !rd_buf) begin
                            ovr <= 1'b1;
                        end
                    end else begin
`ifdef SPART_FRAMING_ERR_EN
                        ferr <= 1'b1;
`endif
                        rx_state <= RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s2) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spart_core.sv
// Directed self-checking bench for spart_core: register table plus TX/RX frame sequences.
module tb_spart_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rxd;
    logic       drv_oe;
    logic [7:0] drv_val;
    wire  [7:0] databus;
    wire        rda;
    wire        tbr;
    wire        txd;

    int total = 0;
    int bad   = 0;

    assign databus = drv_oe ? drv_val : 8'hzz;

    spart_core dut (
        .clk    (clk),
        .rst    (rst),
        .iocs   (iocs),
        .iorw   (iorw),
        .ioaddr (ioaddr),
        .databus(databus),
        .rda    (rda),
        .tbr    (tbr),
        .txd    (txd),
        .rxd    (rxd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [0:13];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        iocs    = 1'b1;
        iorw    = 1'b0;
        ioaddr  = a;
        drv_val = d;
        drv_oe  = 1'b1;
        step();
        iocs    = 1'b0;
        drv_oe  = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string name);
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = a;
        drv_oe = 1'b0;
        #2;
        check(name, int'(databus), int'(exp));
        step();
        iocs   = 1'b0;
        iorw   = 1'b0;
    endtask

    // Send one byte and check txd every cycle of the frame; optionally try a write mid-frame.
    task automatic tx_frame(input logic [7:0] b, input int d, input bit inject);
        logic [9:0] frame;
        int         errs;
        int         tbr_errs;
        frame    = {1'b1, b, 1'b0};
        tbr_errs = 0;
        bus_write(2'b00, b);
        check("tx_tbr_low_after_write", int'(tbr), 0);
        step();
        for (int bit_i = 0; bit_i < 10; bit_i++) begin
            errs = 0;
            for (int c = 0; c < d; c++) begin
                if (txd !== frame[bit_i]) errs++;
                if (tbr !== 1'b0) tbr_errs++;
                if (inject && bit_i == 3 && c == 0) begin
                    iocs    = 1'b1;
                    iorw    = 1'b0;
                    ioaddr  = 2'b00;
                    drv_val = 8'hFF;
                    drv_oe  = 1'b1;
                end else begin
                    iocs   = 1'b0;
                    drv_oe = 1'b0;
                end
                step();
            end
            check($sformatf("tx_bit%0d_wrong_cycles", bit_i), errs, 0);
        end
        check("tx_tbr_low_cycles_wrong", tbr_errs, 0);
        check("tx_tbr_high_after_stop", int'(tbr), 1);
        errs = 0;
        for (int c = 0; c < 12 * d; c++) begin
            if (txd !== 1'b1) errs++;
            step();
        end
        check("tx_idle_after_frame", errs, 0);
    endtask

    // Drive one serial frame on rxd; optionally check rda rises exactly at the expected edge.
    task automatic rx_frame(input logic [7:0] b, input logic stop, input int d, input bit chk_lat);
        logic [9:0] frame;
        int         lat;
        frame = {stop, b, 1'b0};
        lat   = 2 + d / 2 + 9 * d;
        for (int e = 1; e <= 10 * d; e++) begin
            rxd = frame[(e - 1) / d];
            step();
            if (chk_lat && e == lat - 1) check("rx_rda_before_latency", int'(rda), 0);
            if (chk_lat && e == lat) check("rx_rda_at_latency", int'(rda), 1);
        end
        rxd = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        rst     = 1'b1;
        iocs    = 1'b0;
        iorw    = 1'b0;
        ioaddr  = 2'b00;
        rxd     = 1'b1;
        drv_oe  = 1'b0;
        drv_val = 8'h00;

        vecs[0]  = '{1'b0, 2'b01, 8'h00, 8'h02};
        vecs[1]  = '{1'b0, 2'b10, 8'h00, 8'h58};
        vecs[2]  = '{1'b0, 2'b11, 8'h00, 8'h14};
        vecs[3]  = '{1'b0, 2'b00, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 2'b10, 8'h34, 8'h00};
        vecs[5]  = '{1'b0, 2'b10, 8'h00, 8'h34};
        vecs[6]  = '{1'b0, 2'b11, 8'h00, 8'h14};
        vecs[7]  = '{1'b1, 2'b11, 8'h00, 8'h00};
        vecs[8]  = '{1'b1, 2'b10, 8'h10, 8'h00};
        vecs[9]  = '{1'b0, 2'b10, 8'h00, 8'h10};
        vecs[10] = '{1'b0, 2'b11, 8'h00, 8'h00};
        vecs[11] = '{1'b1, 2'b01, 8'hFF, 8'h00};
        vecs[12] = '{1'b0, 2'b01, 8'h00, 8'h02};
        vecs[13] = '{1'b0, 2'b00, 8'h00, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_txd", int'(txd), 1);
        check("reset_tbr", int'(tbr), 1);
        check("reset_rda", int'(rda), 0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
            end
        end

        tx_frame(8'hA5, 16, 1'b1);

        rx_frame(8'h3C, 1'b1, 16, 1'b1);
        bus_read(2'b00, 8'h3C, "rx_buf_3c");
        check("rx_rda_cleared_by_read", int'(rda), 0);

        rx_frame(8'h11, 1'b1, 16, 1'b1);
        rx_frame(8'h22, 1'b1, 16, 1'b0);
        bus_read(2'b01, 8'h07, "ovr_status");
        bus_read(2'b01, 8'h03, "ovr_cleared_status");
        bus_read(2'b00, 8'h22, "ovr_buf_22");
        bus_read(2'b01, 8'h02, "status_after_read");

        rxd = 1'b0;
        repeat (4) step();
        rxd = 1'b1;
        repeat (40) step();
        check("glitch_no_rda", int'(rda), 0);
        bus_read(2'b01, 8'h02, "glitch_status");
        rx_frame(8'h96, 1'b1, 16, 1'b1);
        bus_read(2'b00, 8'h96, "after_glitch_buf");

        rx_frame(8'h7E, 1'b0, 16, 1'b0);
`ifdef SPART_FRAMING_ERR_EN
        check("ferr_no_rda", int'(rda), 0);
        bus_read(2'b01, 8'h0A, "ferr_status");
        bus_read(2'b01, 8'h02, "ferr_cleared_status");
        bus_read(2'b00, 8'h96, "ferr_buf_kept");
`else
        check("stop0_rda", int'(rda), 1);
        bus_read(2'b01, 8'h03, "stop0_status");
        bus_read(2'b00, 8'h7E, "stop0_buf");
`endif

        bus_write(2'b10, 8'h01);
        tx_frame(8'h81, 2, 1'b0);
        rx_frame(8'h4B, 1'b1, 2, 1'b1);
        bus_read(2'b00, 8'h4B, "min_div_rx_buf");

        bus_write(2'b10, 8'h10);
        bus_write(2'b00, 8'hC3);
        repeat (30) step();
        rst = 1'b1;
        #1;
        check("midtx_reset_txd", int'(txd), 1);
        check("midtx_reset_tbr", int'(tbr), 1);
        step();
        step();
        rst = 1'b0;
        step();
        check("post_reset_rda", int'(rda), 0);
        bus_read(2'b10, 8'h58, "post_reset_div_low");
        bus_write(2'b10, 8'h10);
        bus_write(2'b11, 8'h00);
        tx_frame(8'h5A, 16, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
